// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp32_pkg
//  Description : Shared binary32 field widths, constants, packed view and
//                operand classification helpers for the Vector ALU FP units.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp32_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  // Canonical quiet NaN; payloads are never propagated.
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  function automatic logic is_nan(input fp32_t x);
    return (x.exp == EXP_W'(EXP_MAX)) && (x.frac != '0);
  endfunction

  function automatic logic is_inf(input fp32_t x);
    return (x.exp == EXP_W'(EXP_MAX)) && (x.frac == '0);
  endfunction

  function automatic logic is_zero(input fp32_t x);
    return (x.exp == '0) && (x.frac == '0);
  endfunction

  function automatic logic is_sub(input fp32_t x);
    return (x.exp == '0) && (x.frac != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lzc24.sv
`default_nettype none
// ============================================================================
//  Module      : fp_lzc24
//  Description : Leading-zero counter for 24/25-bit mantissa fields. An
//                all-zero input reports WIDTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_lzc24 #(
  parameter int WIDTH = 24,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CNT_W-1:0] count
);

  // Scan LSB to MSB so the highest set bit has the final say
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) begin
        count = CNT_W'(WIDTH - 1 - i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/float_adder_32.sv
`default_nettype none
// ============================================================================
//  Module      : float_adder_32
//  Description : IEEE-754 binary32 adder, round-to-nearest-even, with NaN and
//                overflow flags. Combinational datapath, one output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module float_adder_32
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] out,
  output logic        NaN_flag,
  output logic        overflow_flag
);

  fp32_t       a_f, b_f;
  logic [7:0]  ea, eb, ex, ey, ediff;
  logic [23:0] ma, mb, mx, my;
  logic        a_big, sx, eff_sub;
  logic [49:0] y_wide;
  logic [26:0] x_ext, y_ext;     // {mantissa[23:0], guard, round, sticky}
  logic [27:0] sum_raw;          // carry-out on top of the 27-bit field
  logic [4:0]  lz;

  logic [7:0]  sh_lim, sh_amt;
  logic [26:0] n_sh;
  logic [23:0] m_norm, m_fin;
  logic        g_bit, r_bit, s_bit, rnd_up;
  logic [24:0] m_rnd;
  logic [9:0]  e_norm, e_fin;

  logic [31:0] out_d, out_q;
  logic        nan_d, nan_q, ovf_d, ovf_q;

  // Unpack, order by magnitude, align the smaller operand and add/subtract
  always_comb begin
    a_f     = A;
    b_f     = B;
    ea      = (a_f.exp == '0) ? 8'd1 : a_f.exp;
    eb      = (b_f.exp == '0) ? 8'd1 : b_f.exp;
    ma      = {(a_f.exp != '0), a_f.frac};
    mb      = {(b_f.exp != '0), b_f.frac};
    a_big   = (ea > eb) || ((ea == eb) && (ma >= mb));
    sx      = a_big ? a_f.sign : b_f.sign;
    ex      = a_big ? ea : eb;
    ey      = a_big ? eb : ea;
    mx      = a_big ? ma : mb;
    my      = a_big ? mb : ma;
    eff_sub = a_f.sign ^ b_f.sign;
    ediff   = ex - ey;
    x_ext   = {mx, 3'b000};
    // Bits shifted below the round position all collapse into sticky
    y_wide  = {my, 26'd0} >> ediff;
    if (ediff >= 8'd26) begin
      y_ext = {26'd0, |my};
    end else begin
      y_ext = {y_wide[49:24], |y_wide[23:0]};
    end
    if (eff_sub) begin
      sum_raw = {1'b0, x_ext} - {1'b0, y_ext};
    end else begin
      sum_raw = {1'b0, x_ext} + {1'b0, y_ext};
    end
  end

  // Mantissa plus guard: a d<=1 cancellation can leave only the guard set
  fp_lzc24 #(
    .WIDTH (25)
  ) u_lzc (
    .din   (sum_raw[26:2]),
    .count (lz)
  );

  // Normalize, round to nearest even, encode, then apply special cases
  always_comb begin
    sh_lim = ex - 8'd1;
    sh_amt = 8'd0;
    n_sh   = sum_raw[26:0];
    m_norm = sum_raw[26:3];
    g_bit  = sum_raw[2];
    r_bit  = sum_raw[1];
    s_bit  = sum_raw[0];
    e_norm = {2'b00, ex};
    if (sum_raw[27]) begin
      m_norm = sum_raw[27:4];
      g_bit  = sum_raw[3];
      r_bit  = sum_raw[2];
      s_bit  = |sum_raw[1:0];
      e_norm = {2'b00, ex} + 10'd1;
    end else begin
      // Stop at exponent 1 so tiny results come out subnormal
      sh_amt = ({3'b000, lz} > sh_lim) ? sh_lim : {3'b000, lz};
      n_sh   = sum_raw[26:0] << sh_amt;
      m_norm = n_sh[26:3];
      g_bit  = n_sh[2];
      r_bit  = n_sh[1];
      s_bit  = n_sh[0];
      e_norm = {2'b00, ex} - {2'b00, sh_amt};
    end

    rnd_up = g_bit & (r_bit | s_bit | m_norm[0]);
    m_rnd  = {1'b0, m_norm} + {24'd0, rnd_up};
    if (m_rnd[24]) begin
      m_fin = m_rnd[24:1];
      e_fin = e_norm + 10'd1;
    end else begin
      m_fin = m_rnd[23:0];
      e_fin = e_norm;
    end

    out_d = 32'd0;
    nan_d = 1'b0;
    ovf_d = 1'b0;
    if (is_nan(a_f) || is_nan(b_f)) begin
      out_d = QNAN;
      nan_d = 1'b1;
    end else if (is_inf(a_f) && is_inf(b_f) && (a_f.sign != b_f.sign)) begin
      out_d = QNAN;
      nan_d = 1'b1;
    end else if (is_inf(a_f)) begin
      out_d = a_f;
    end else if (is_inf(b_f)) begin
      out_d = b_f;
    end else if (is_zero(a_f) && is_zero(b_f)) begin
      out_d = {a_f.sign & b_f.sign, 31'd0};
    end else if (sum_raw == '0) begin
      out_d = 32'd0;
    end else if (e_fin >= 10'(EXP_MAX)) begin
      out_d = {sx, 8'hFF, 23'd0};
      ovf_d = 1'b1;
    end else if (!m_fin[23]) begin
      out_d = {sx, 8'h00, m_fin[22:0]};
    end else begin
      out_d = {sx, e_fin[7:0], m_fin[22:0]};
    end
  end

  // Single output register; reset clears result and flags asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 32'd0;
      nan_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      nan_q <= nan_d;
      ovf_q <= ovf_d;
    end
  end

  assign out           = out_q;
  assign NaN_flag      = nan_q;
  assign overflow_flag = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_float_adder_32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_float_adder_32
//  Description : Self-checking bench for float_adder_32 against an exact
//                wide-integer reference sum with a single final rounding.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_float_adder_32;

  logic        clk;
  logic        rst_n;
  logic [31:0] A, B;
  logic [31:0] out;
  logic        NaN_flag, overflow_flag;

  int checks;
  int errors;

  float_adder_32 dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .A             (A),
    .B             (B),
    .out           (out),
    .NaN_flag      (NaN_flag),
    .overflow_flag (overflow_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {nan, ovf, result}. Operands become exact integers in
  // units of 2^-149, are summed exactly, and the sum is rounded once (RNE).
  function automatic logic [33:0] model_add(input logic [31:0] a, input logic [31:0] b);
    logic         sa, sb, sr;
    logic [7:0]   ea, eb;
    logic [22:0]  fa, fb;
    logic [279:0] va, vb, mag, q, rem, half, one;
    int           p, shift, bexp;
    logic         a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    sa = a[31]; ea = a[30:23]; fa = a[22:0];
    sb = b[31]; eb = b[30:23]; fb = b[22:0];
    a_nan  = (ea == 8'hFF) && (fa != 0);
    b_nan  = (eb == 8'hFF) && (fb != 0);
    a_inf  = (ea == 8'hFF) && (fa == 0);
    b_inf  = (eb == 8'hFF) && (fb == 0);
    a_zero = (ea == 0) && (fa == 0);
    b_zero = (eb == 0) && (fb == 0);
    if (a_nan || b_nan) return {2'b10, 32'h7FC00000};
    if (a_inf && b_inf && (sa != sb)) return {2'b10, 32'h7FC00000};
    if (a_inf) return {2'b00, a};
    if (b_inf) return {2'b00, b};
    if (a_zero && b_zero) return {2'b00, sa & sb, 31'd0};
    one = 280'd1;
    va = 280'({(ea != 0), fa}) << ((ea == 0) ? 0 : int'(ea) - 1);
    vb = 280'({(eb != 0), fb}) << ((eb == 0) ? 0 : int'(eb) - 1);
    if (sa == sb) begin
      mag = va + vb; sr = sa;
    end else if (va >= vb) begin
      mag = va - vb; sr = sa;
    end else begin
      mag = vb - va; sr = sb;
    end
    if (mag == 0) return 34'd0;
    p = 0;
    for (int i = 0; i < 280; i++) if (mag[i]) p = i;
    if (p <= 23) return {2'b00, sr, mag[30:0]};
    shift = p - 23;
    q     = mag >> shift;
    rem   = mag & ((one << shift) - one);
    half  = one << (shift - 1);
    if ((rem > half) || ((rem == half) && q[0])) q = q + one;
    if (q[24]) begin
      q = q >> 1;
      shift++;
    end
    bexp = shift + 1;
    if (bexp >= 255) return {2'b01, sr, 8'hFF, 23'd0};
    return {2'b00, sr, 8'(bexp), q[22:0]};
  endfunction

  // Operand mix biased towards the interesting corners
  function automatic logic [31:0] rand_op(input logic [31:0] other);
    logic [31:0] v;
    int k;
    k = $urandom_range(0, 9);
    v = $urandom;
    case (k)
      3: v = {v[31], 8'($urandom_range(0, 3)), v[22:0]};
      4: v = other ^ 32'h8000_0000 ^ 32'($urandom_range(0, 7));
      5: begin
        case ($urandom_range(0, 5))
          0: v = 32'h7F80_0000;
          1: v = 32'hFF80_0000;
          2: v = 32'h0000_0000;
          3: v = 32'h8000_0000;
          4: v = 32'h7F7F_FFFF;
          default: v = 32'hFFC0_1234;
        endcase
      end
      6: v = {~other[31], other[30:23], v[22:0]};
      7: v = {v[31], 8'($urandom_range(250, 254)), v[22:0]};
      8: v = {v[31], 8'(int'(other[30:23]) + $urandom_range(0, 30) - 15), v[22:0]};
      default: v = {v[31], 8'($urandom_range(100, 154)), v[22:0]};
    endcase
    return v;
  endfunction

  task automatic apply(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    A = a;
    B = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    A = 32'h3F80_0000;
    B = 32'h4000_0000;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out !== 32'd0) begin
      errors++;
      $display("FAIL reset_out got %h exp 00000000", out);
    end
    checks++;
    if (NaN_flag !== 1'b0 || overflow_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got nan=%b ovf=%b exp 0 0", NaN_flag, overflow_flag);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] va [22];
    logic [31:0] vb [22];
    logic [33:0] ve [22];
    va = '{32'h7F800000, 32'hFF800000, 32'hFF800000, 32'h7F800000, 32'h00000001,
           32'h01800000, 32'h01800000, 32'h7F7FFFFF, 32'h3F800000, 32'hBF800000,
           32'hC0000000, 32'h3F800000, 32'h7FC00001, 32'h80000000, 32'h80000000,
           32'h00400000, 32'h00800000, 32'h3F800000, 32'h3F800001, 32'h7F7FFFFF,
           32'h7F7FFFFF, 32'h3F800000};
    vb = '{32'h00000000, 32'h00000613, 32'h7F800000, 32'h7F800000, 32'h00000002,
           32'h00800000, 32'h01800000, 32'h7F7FFFFF, 32'hBF800000, 32'h40000000,
           32'hBF800000, 32'h33800000, 32'h3F800000, 32'h80000000, 32'h00000000,
           32'h00400000, 32'h80000001, 32'h33800001, 32'h33800000, 32'h73000000,
           32'h72FFFFFF, 32'h00000001};
    ve = '{{2'b00, 32'h7F800000}, {2'b00, 32'hFF800000}, {2'b10, 32'h7FC00000},
           {2'b00, 32'h7F800000}, {2'b00, 32'h00000003}, {2'b00, 32'h01A00000},
           {2'b00, 32'h02000000}, {2'b01, 32'h7F800000}, {2'b00, 32'h00000000},
           {2'b00, 32'h3F800000}, {2'b00, 32'hC0400000}, {2'b00, 32'h3F800000},
           {2'b10, 32'h7FC00000}, {2'b00, 32'h80000000}, {2'b00, 32'h00000000},
           {2'b00, 32'h00800000}, {2'b00, 32'h007FFFFF}, {2'b00, 32'h3F800001},
           {2'b00, 32'h3F800002}, {2'b01, 32'h7F800000}, {2'b00, 32'h7F7FFFFF},
           {2'b00, 32'h3F800000}};
    for (int i = 0; i < 22; i++) begin
      apply(va[i], vb[i]);
      checks++;
      if ({NaN_flag, overflow_flag, out} !== ve[i]) begin
        errors++;
        $display("FAIL directed[%0d] %h+%h got out=%h nan=%b ovf=%b exp out=%h nan=%b ovf=%b",
                 i, va[i], vb[i], out, NaN_flag, overflow_flag, ve[i][31:0], ve[i][33], ve[i][32]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [33:0] e;
    for (int i = 0; i < 3000; i++) begin
      a = $urandom;
      b = rand_op(a);
      if ($urandom_range(0, 1) == 1) begin
        a = rand_op(b);
      end
      e = model_add(a, b);
      apply(a, b);
      checks++;
      if ({NaN_flag, overflow_flag, out} !== e) begin
        errors++;
        $display("FAIL random %h+%h got out=%h nan=%b ovf=%b exp out=%h nan=%b ovf=%b",
                 a, b, out, NaN_flag, overflow_flag, e[31:0], e[33], e[32]);
      end
    end
  endtask

  // New operands every cycle: outputs must hold until the edge, then update
  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic [33:0] prev, e;
    a = $urandom;
    b = rand_op(a);
    prev = model_add(a, b);
    apply(a, b);
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      b = rand_op(a);
      e = model_add(a, b);
      @(negedge clk);
      A = a;
      B = b;
      #2;
      checks++;
      if ({NaN_flag, overflow_flag, out} !== prev) begin
        errors++;
        $display("FAIL hold[%0d] got out=%h exp out=%h before edge", i, out, prev[31:0]);
      end
      A = ~a;
      B = rand_op(~a);
      #2;
      A = a;
      B = b;
      @(posedge clk);
      #1;
      checks++;
      if ({NaN_flag, overflow_flag, out} !== e) begin
        errors++;
        $display("FAIL b2b[%0d] %h+%h got out=%h nan=%b ovf=%b exp out=%h nan=%b ovf=%b",
                 i, a, b, out, NaN_flag, overflow_flag, e[31:0], e[33], e[32]);
      end
      prev = e;
    end
  endtask

  task automatic test_reset_midstream();
    logic [33:0] e;
    apply(32'h7F7FFFFF, 32'h7F7FFFFF);
    checks++;
    if (overflow_flag !== 1'b1 || out !== 32'h7F800000) begin
      errors++;
      $display("FAIL pre_reset got out=%h ovf=%b exp out=7f800000 ovf=1", out, overflow_flag);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({NaN_flag, overflow_flag, out} !== 34'd0) begin
      errors++;
      $display("FAIL async_reset got out=%h nan=%b ovf=%b exp 0", out, NaN_flag, overflow_flag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    A = 32'hC000_0000;
    B = 32'hBF80_0000;
    e = model_add(A, B);
    #1;
    checks++;
    if (out !== 32'd0) begin
      errors++;
      $display("FAIL release_no_edge got out=%h exp 00000000", out);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({NaN_flag, overflow_flag, out} !== e) begin
      errors++;
      $display("FAIL first_after_reset got out=%h exp out=%h", out, e[31:0]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    A = 32'd0;
    B = 32'd0;
    rst_n = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/float_adder_32.md
# float_adder_32

Single-precision (IEEE-754 binary32) floating-point adder for the Vector ALU of the compute unit. It takes two 32-bit operands, returns their correctly rounded sum, and reports NaN results and overflow through dedicated flags. The datapath is combinational, and the result and flags are registered once, giving a fixed one-cycle latency.

## Interface
Clock is single; reset is asynchronous, active-low.

Parameters: none.

Ports:
- clk  in  1  sole clock; all state on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- A  in  32  operand A, binary32 (sign[31], exp[30:23], frac[22:0])
- B  in  32  operand B, binary32
- out  out  32  registered sum A+B, binary32
- NaN_flag  out  1  registered; 1 when `out` is NaN
- overflow_flag  out  1  registered; 1 when finite operands produced ±inf through exponent overflow

## Operation
Special-case priority, highest first:
- **NaN input.** Either operand NaN (exp=255, frac≠0) gives out=0x7FC00000 and NaN_flag=1.
- **Opposite infinities.** +inf plus -inf, in either order, gives out=0x7FC00000 and NaN_flag=1.
- **Infinity input.** Any other infinity operand gives that infinity, including its sign. Both flags are 0.
- **Two zeros.** Both operands zero gives a result sign equal to sA AND sB, so +0 unless both are -0.

Finite path:
- **Unpack.**
  - Normal operand: mantissa {1,frac}, exponent e.
  - Subnormal operand: mantissa {0,frac}, exponent 1.
- **Align.** Swap so the larger magnitude (exponent, then mantissa) is operand X. Right-shift Y by the exponent difference, keeping guard, round and sticky bits. A shift of 26 or more collapses Y to sticky only.
- **Add or subtract.**
  - Equal signs: add mantissas into a 25-bit result.
  - Unequal signs: compute X−Y.
  - Result sign is the sign of X.
  - An exact-zero difference gives +0.
- **Normalize.**
  - On carry-out: right-shift by 1 and increment the exponent, folding the shifted bit into sticky.
  - Otherwise: left-shift by the leading-zero count, but never below exponent 1. This produces subnormals.
- **Round.** Round to nearest, ties to even, on guard/round/sticky. A rounding carry renormalizes, which may turn a subnormal into the minimum normal or bump the exponent.
- **Overflow.** A final exponent of 255 or more gives out=±inf (sign preserved), frac=0, overflow_flag=1.
- **Flags.** NaN_flag is 0 for every finite-path result.
- **Bit-exactness.** Results match IEEE-754 round-to-nearest-even for all non-NaN cases. NaN payloads are not propagated; the canonical quiet NaN is always returned.

## Timing
- Operands are sampled every rising clk edge. out and the flags for the operands present at edge N are valid after edge N, giving 1-cycle latency and a throughput of 1 per cycle.
- There is no handshake; the block computes every cycle.
- While rst_n=0: out=0x00000000, NaN_flag=0, overflow_flag=0, asynchronously.
- The first valid result appears after the first rising edge following rst_n deassertion.
- If reset is asserted mid-stream, the in-flight result is discarded and outputs return to their reset values immediately.
- Operand changes between edges have no effect on outputs until the next edge.
- The combinational path (align, add, leading-zero count, normalize, round) must close in one cycle.

## Structure
- Shared package `fp32_pkg`:
  - field-width constants: EXP_W=8, FRAC_W=23, BIAS=127
  - EXP_MAX=255
  - QNAN=32'h7FC00000
  - a packed struct {sign, exp, frac}
  - classification helpers: is_nan, is_inf, is_zero, is_sub
- One sub-module, `fp_lzc24`: a 24/25-bit leading-zero counter, reusable by the multiplier and FMA.
- All other logic stays in float_adder_32: one combinational block feeding one output register.

## Test plan
- **Infinity propagation.** 0x7F800000+0x00000000 → 0x7F800000, flags 0. 0xFF800000+0x00000613 → 0xFF800000, flags 0.
- **Opposite infinities.** 0xFF800000+0x7F800000 → 0x7FC00000, NaN_flag=1. 0x7F800000+0x7F800000 → 0x7F800000, flags 0.
- **Subnormal and small normals.**
  - 0x00000001+0x00000002 → 0x00000003.
  - 0x01800000+0x00800000 → 0x01A00000.
  - 0x01800000+0x01800000 → 0x02000000.
- **Overflow.** 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000, overflow_flag=1.
- **Signs and cancellation.**
  - 0x3F800000+0xBF800000 → 0x00000000.
  - 0xBF800000+0x40000000 → 0x3F800000.
  - 0xC0000000+0xBF800000 → 0xC0400000.
- **Rounding, reset and latency.**
  - Ties-to-even: 0x3F800000+0x33800000 → 0x3F800000.
  - Reset: rst_n low mid-stream → outputs 0 immediately.
  - Latency: a result appears exactly one edge after its operands are sampled.
